// File: rtl/mmio_port_responder_pkg.sv
// mmio_port_responder_pkg
//   Shared definitions for the MMIO port responder:
//   - register offsets within the 16-byte window (word index Address[3:2])
//   - STATUS register bit positions and a helper that packs the STATUS word
package mmio_port_responder_pkg;

  typedef enum logic [1:0] {
    OFS_PORT_OUT = 2'd0,
    OFS_PORT_IN  = 2'd1,
    OFS_STATUS   = 2'd2,
    OFS_FIFO     = 2'd3
  } reg_ofs_e;

  // STATUS = {26'b0, count[4:0], ovf}
  localparam int STAT_OVF_BIT = 0;
  localparam int STAT_CNT_LSB = 1;
  localparam int STAT_CNT_W   = 5;

  function automatic logic [31:0] pack_status(input logic [STAT_CNT_W-1:0] cnt,
                                              input logic                  ovf);
    logic [31:0] w;
    w = '0;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    w[STAT_OVF_BIT]               = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mmio_port_responder_capture_fifo.sv
// capture_fifo
//   Small circular FIFO that queues synchronised PortIn bytes.
//   Ports:
//     clk, reset      clock, synchronous active-low reset (clears pointers/count)
//     push, pop       requests; pop on empty is a harmless no-op
//     din             byte to store on an accepted push
//     dout            head entry, 0 while empty
//     count           number of stored entries (AW+1 bits)
//     full, empty     occupancy flags
//     ovf_set         a push was dropped this cycle (full and no pop)
module capture_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             ovf_set
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

  // A pop on a full FIFO frees the slot the simultaneous push needs,
  // so push+pop when full is a clean exchange rather than an overflow.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign ovf_set   = push & full & ~w_do_pop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_port_responder.sv
// mmio_port_responder
//   Target end of the core's data-side load/store bus for a 16-byte I/O window.
//   Word registers: PORT_OUT (RW), PORT_IN (RO), STATUS (count RO, ovf W1C),
//   FIFO_DATA (RO, read pops). Every change of the synchronised PortIn is queued.
//   Ports:
//     clk, reset          clock, synchronous active-low reset
//     Address, WriteData  bus address / store data
//     MemWrite, MemRead   one-cycle store / load strobes
//     PortIn              asynchronous 8-bit inputs
//     ReadData            combinational load data (0 when no hit)
//     HitOut              access falls in the window
//     PortOut             registered output port
//     IrqOut              capture FIFO not empty
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [7:0]  PortIn,
  output logic [31:0] ReadData,
  output logic        HitOut,
  output logic [31:0] PortOut,
  output logic        IrqOut
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] r_port_out;
  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic [7:0]  r_prev;
  logic        r_ovf;

  reg_ofs_e    w_ofs;
  logic        w_hit;
  logic        w_wr;
  logic        w_pop;
  logic        w_push;
  logic [7:0]  w_head;
  logic [CW-1:0] w_count;
  logic        w_full;
  logic        w_empty;
  logic        w_ovf_set;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_ofs  = reg_ofs_e'(Address[3:2]);
  assign w_hit  = (Address[31:4] == BASE_ADDR[31:4]) & (MemRead | MemWrite);
  assign w_wr   = w_hit & MemWrite;
  // A combined read+write strobe is treated as a write: it must not pop.
  assign w_pop  = w_hit & MemRead & ~MemWrite & (w_ofs == OFS_FIFO);
  assign w_push = (r_sync2 != r_prev);

  capture_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .pop     (w_pop),
    .din     (r_sync2),
    .dout    (w_head),
    .count   (w_count),
    .full    (w_full),
    .empty   (w_empty),
    .ovf_set (w_ovf_set)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_port_out <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_sync1 <= PortIn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_wr && w_ofs == OFS_PORT_OUT) r_port_out <= WriteData;
      // A fresh overflow outranks a same-edge W1C so it is never lost.
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_wr && w_ofs == OFS_STATUS && WriteData[STAT_OVF_BIT])
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_ofs)
        OFS_PORT_OUT: w_rdata = r_port_out;
        OFS_PORT_IN:  w_rdata = {24'b0, r_sync2};
        OFS_STATUS:   w_rdata = pack_status(STAT_CNT_W'(w_count), r_ovf);
        OFS_FIFO:     w_rdata = {24'b0, w_head};
        default:      w_rdata = '0;
      endcase
    end
  end

  assign ReadData = w_rdata;
  assign HitOut   = w_hit;
  assign PortOut  = r_port_out;
  assign IrqOut   = (w_count != '0);

  // Byte lane bits and the full flag have no consumer at this level.
  assign w_unused = ^{Address[1:0], w_full, w_empty};

endmodule

// File: tb/tb_mmio_port_responder.sv
module tb_mmio_port_responder;
  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData, PortOut;
  logic        MemWrite, MemRead, HitOut, IrqOut;
  logic [7:0]  PortIn;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] fifo_q[$];   // scoreboard of bytes expected out of FIFO_DATA

  always #5 clk = ~clk;

  mmio_port_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
    .ReadData(ReadData), .HitOut(HitOut), .PortOut(PortOut), .IrqOut(IrqOut)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic [31:0] exp_pout;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Address = 32'h0; WriteData = 32'h0; MemWrite = 1'b0; MemRead = 1'b0;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
    tick();
    idle();
  endtask

  task automatic lw(input string nm, input logic [31:0] a, input logic [31:0] exp);
    Address = a; MemRead = 1'b1; MemWrite = 1'b0;
    #1;
    chk(nm, ReadData, exp);
    tick();
    idle();
  endtask

  task automatic lw_fifo(input string nm);
    logic [31:0] e;
    e = (fifo_q.size() != 0) ? {24'b0, fifo_q.pop_front()} : 32'h0;
    lw(nm, BASE + 32'hC, e);
  endtask

  task automatic status(input string nm, input int cnt, input logic ovf);
    lw(nm, BASE + 32'h8, {26'b0, 5'(cnt), ovf});
  endtask

  // Drive one PortIn value per cycle; keep=1 means the FIFO should accept it.
  task automatic port_seq(input logic [7:0] v, input logic keep);
    PortIn = v;
    if (keep) fifo_q.push_back(v);
    tick();
  endtask

  initial begin
    vecs[0]  = '{BASE + 32'h0,  32'hDEAD_BEEF, 1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF};
    vecs[1]  = '{BASE + 32'h0,  32'h0,         0, 1, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[2]  = '{BASE + 32'h3,  32'h0,         0, 1, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[3]  = '{BASE + 32'h4,  32'h0,         0, 1, 1, 32'h0,         1, 32'hDEAD_BEEF};
    vecs[4]  = '{BASE + 32'h4,  32'h0000_FFFF, 1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF};
    vecs[5]  = '{BASE + 32'h8,  32'h0,         0, 1, 1, 32'h0,         1, 32'hDEAD_BEEF};
    vecs[6]  = '{BASE + 32'h10, 32'h0,         0, 1, 1, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[7]  = '{BASE + 32'h10, 32'h1,         1, 0, 1, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[8]  = '{BASE - 32'h4,  32'h2,         1, 0, 1, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[9]  = '{BASE + 32'hC,  32'h0,         0, 1, 1, 32'h0,         1, 32'hDEAD_BEEF};
    vecs[10] = '{BASE + 32'h0,  32'h0,         0, 0, 1, 32'h0,         0, 32'hDEAD_BEEF};
    vecs[11] = '{BASE + 32'h0,  32'h0000_00FF, 1, 0, 0, 32'h0,         1, 32'h0000_00FF};

    reset = 1'b0; PortIn = 8'h00; idle();
    tick(); tick();
    chk("rst_portout", PortOut, 32'h0);
    chk("rst_irq", {31'b0, IrqOut}, 32'h0);
    chk("rst_hit", {31'b0, HitOut}, 32'h0);
    reset = 1'b1;
    status("rst_status", 0, 1'b0);

    // register access table
    for (int i = 0; i < 12; i++) begin
      Address = vecs[i].addr; WriteData = vecs[i].wdata;
      MemWrite = vecs[i].we;  MemRead = vecs[i].re;
      #1;
      chk($sformatf("vec%0d_hit", i), {31'b0, HitOut}, {31'b0, vecs[i].exp_hit});
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
      tick();
      chk($sformatf("vec%0d_pout", i), PortOut, vecs[i].exp_pout);
      idle();
    end

    // single PortIn change: PORT_IN after 2 edges, IRQ after 3
    PortIn = 8'h5A; fifo_q.push_back(8'h5A);
    tick(); tick();
    chk("in_irq_early", {31'b0, IrqOut}, 32'h0);
    lw("in_portin", BASE + 32'h4, 32'h5A);
    chk("in_irq", {31'b0, IrqOut}, 32'h1);
    status("in_cnt1", 1, 1'b0);
    lw_fifo("in_pop");
    status("in_cnt0", 0, 1'b0);
    chk("in_irq_off", {31'b0, IrqOut}, 32'h0);

    // overflow: five changes into a 4-deep FIFO, fifth is dropped
    for (int v = 1; v <= 5; v++) port_seq(8'(v), v <= 4);
    tick(); tick(); tick();
    status("ovf_stat", 4, 1'b1);
    for (int k = 0; k < 4; k++) lw_fifo($sformatf("ovf_pop%0d", k));
    status("ovf_hold", 0, 1'b1);
    sw(BASE + 32'h8, 32'h0);
    status("ovf_w0", 0, 1'b1);
    sw(BASE + 32'h8, 32'h1);
    status("ovf_w1c", 0, 1'b0);

    // full FIFO with a push landing on the same edge as a pop
    for (int v = 8'h11; v <= 8'h14; v++) port_seq(8'(v), 1'b1);
    tick(); tick(); tick();
    status("full_stat", 4, 1'b0);
    Address = BASE + 32'hC; WriteData = 32'h0; MemRead = 1'b1; MemWrite = 1'b1;
    tick(); idle();
    status("rw_nopop", 4, 1'b0);
    PortIn = 8'h15; fifo_q.push_back(8'h15);
    tick(); tick();
    lw_fifo("xchg_pop");
    status("xchg_stat", 4, 1'b0);
    for (int k = 0; k < 4; k++) lw_fifo($sformatf("wrap_pop%0d", k));
    status("wrap_empty", 0, 1'b0);

    // empty pop and out-of-window accesses
    lw_fifo("empty_pop");
    status("empty_cnt", 0, 1'b0);
    Address = BASE + 32'h10; MemRead = 1'b1;
    #1;
    chk("oow_hit", {31'b0, HitOut}, 32'h0);
    chk("oow_rd", ReadData, 32'h0);
    tick(); idle();
    sw(BASE + 32'h10, 32'h0000_AAAA);
    chk("oow_pout", PortOut, 32'h0000_00FF);

    // reset with 3 bytes queued
    for (int v = 8'h21; v <= 8'h23; v++) port_seq(8'(v), 1'b1);
    tick(); tick(); tick();
    status("pre_rst", 3, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    fifo_q.delete();
    chk("mid_rst_pout", PortOut, 32'h0);
    chk("mid_rst_irq", {31'b0, IrqOut}, 32'h0);
    status("mid_rst_stat", 0, 1'b0);
    // sync flops restarted from 0, so the held 0x23 registers as a new change
    fifo_q.push_back(8'h23);
    tick(); tick();
    chk("post_rst_irq", {31'b0, IrqOut}, 32'h1);
    lw_fifo("post_rst_pop");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
